// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and types for the decode-stage register file and its busy scoreboard.
// Default geometry, register address type and the PC-alias register index.
package rf_pkg;

  localparam int BITS_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 16;
  localparam int NRD_DEFAULT   = 2;
  localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

  typedef logic [AW_DEFAULT-1:0] reg_addr_t;

  localparam reg_addr_t PC_REG_DEFAULT = reg_addr_t'(NREGS_DEFAULT - 1);

  function automatic int addr_width(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle for the register file: read ports, write port, issue and kill info.
// The master side is the decoder plus writeback; the slave side is the register file.
interface regfile_scoreboard_if
  import rf_pkg::*;
#(
  parameter int BITS  = BITS_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NRD   = NRD_DEFAULT
);
  localparam int AW = addr_width(NREGS);

  logic [NRD-1:0][AW-1:0]   ra;
  logic [NRD-1:0]           rd_en;
  logic [NRD-1:0][BITS-1:0] rd;
  logic [NRD-1:0]           rd_busy;
  logic [BITS-1:0]          pc_plus8;
  logic                     we;
  logic [AW-1:0]            wa;
  logic [BITS-1:0]          wd;
  logic                     issue_valid;
  logic                     issue_we;
  logic [AW-1:0]            issue_wa;
  logic                     issue_long;
  logic                     kill;
  logic [AW-1:0]            kill_wa;
  logic                     stall;
  logic [AW:0]              busy_cnt;
  logic [31:0]              stall_cycles;

  modport master (
    output ra, rd_en, pc_plus8, we, wa, wd,
           issue_valid, issue_we, issue_wa, issue_long, kill, kill_wa,
    input  rd, rd_busy, stall, busy_cnt, stall_cycles
  );

  modport slave (
    input  ra, rd_en, pc_plus8, we, wa, wd,
           issue_valid, issue_we, issue_wa, issue_long, kill, kill_wa,
    output rd, rd_busy, stall, busy_cnt, stall_cycles
  );

endinterface

// File: rtl/regfile_scoreboard_busy_table.sv
// Per-register pending-result bits: clear on writeback or kill, set by a newly issued long op.
// Provides raw busy lookups per read port and for the issue destination, plus the busy count.
module busy_table
  import rf_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NRD   = NRD_DEFAULT,
  parameter int AW    = addr_width(NREGS)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic                   kill,
  input  logic [AW-1:0]          kill_wa,
  input  logic                   set_en,
  input  logic [AW-1:0]          set_wa,
  input  logic [NRD-1:0][AW-1:0] ra,
  input  logic [AW-1:0]          dst_wa,
  output logic [NRD-1:0]         busy_rd,
  output logic                   busy_dst,
  output logic [AW:0]            busy_cnt
);

  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;

  // Later assignments win: the set belongs to the newest op, so it overrides any clear.
  always_comb begin
    busy_next = busy_reg;
    if (we)     busy_next[wa]      = 1'b0;
    if (kill)   busy_next[kill_wa] = 1'b0;
    if (set_en) busy_next[set_wa]  = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) busy_reg <= '0;
    else       busy_reg <= busy_next;
  end

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < NREGS; i++)
      busy_cnt = busy_cnt + {{AW{1'b0}}, busy_reg[i]};
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_lookup
      assign busy_rd[gi] = busy_reg[ra[gi]];
    end
  endgenerate

  assign busy_dst = busy_reg[dst_wa];

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with write-through bypass, PC aliasing, busy scoreboard
// and an issue-stall generator with a saturating stalled-cycle counter.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int BITS   = BITS_DEFAULT,
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NRD    = NRD_DEFAULT,
  parameter int PC_REG = NREGS - 1
) (
  input logic                CLK,
  input logic                RESET,
  regfile_scoreboard_if.slave bus
);

  localparam int AW = addr_width(NREGS);
  localparam logic [AW-1:0] PC_A = AW'(PC_REG);

  logic [BITS-1:0]  mem_reg [NREGS];
  logic [NRD-1:0]   busy_rd;
  logic [NRD-1:0]   rd_busy_w;
  logic             busy_dst;
  logic             stall_w;
  logic             set_en;
  logic             src_hz;
  logic             dst_hz;
  logic [31:0]      stall_cycles_reg;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) mem_reg[i] <= '0;
    end else if (bus.we && bus.wa != PC_A) begin
      mem_reg[bus.wa] <= bus.wd;
    end
  end

  // PC alias beats the bypass, and the bypass hides a busy bit that is being cleared now.
  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic hit_pc;
      logic hit_byp;
      assign hit_pc        = (bus.ra[gi] == PC_A);
      assign hit_byp       = bus.we && (bus.wa == bus.ra[gi]);
      assign bus.rd[gi]    = hit_pc  ? bus.pc_plus8 :
                             hit_byp ? bus.wd       : mem_reg[bus.ra[gi]];
      assign rd_busy_w[gi] = !hit_pc && !hit_byp && busy_rd[gi];
    end
  endgenerate

  assign bus.rd_busy = rd_busy_w;

  assign src_hz  = |(bus.rd_en & rd_busy_w);
  assign dst_hz  = bus.issue_we && (bus.issue_wa != PC_A) && busy_dst &&
                   !(bus.we && bus.wa == bus.issue_wa);
  assign stall_w = bus.issue_valid && (src_hz || dst_hz);
  assign set_en  = bus.issue_valid && bus.issue_we && bus.issue_long && !stall_w &&
                   (bus.issue_wa != PC_A);

  busy_table #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) u_busy (
    .CLK      (CLK),
    .RESET    (RESET),
    .we       (bus.we),
    .wa       (bus.wa),
    .kill     (bus.kill),
    .kill_wa  (bus.kill_wa),
    .set_en   (set_en),
    .set_wa   (bus.issue_wa),
    .ra       (bus.ra),
    .dst_wa   (bus.issue_wa),
    .busy_rd  (busy_rd),
    .busy_dst (busy_dst),
    .busy_cnt (bus.busy_cnt)
  );

  always_ff @(posedge CLK) begin
    if (RESET)
      stall_cycles_reg <= '0;
    else if (stall_w && stall_cycles_reg != 32'hFFFF_FFFF)
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
  end

  assign bus.stall        = stall_w;
  assign bus.stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: stimulus queues hand-computed expectations, a negedge monitor pops and checks them.
module tb_regfile_scoreboard;
  import rf_pkg::*;

  localparam int SEL_RD0 = 0, SEL_RD1 = 1, SEL_RDB0 = 2, SEL_RDB1 = 3,
                 SEL_STALL = 4, SEL_CNT = 5, SEL_SCY = 6;

  typedef struct {
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  regfile_scoreboard_if #(.BITS(32), .NREGS(16), .NRD(2)) bus ();

  regfile_scoreboard #(.BITS(32), .NREGS(16), .NRD(2), .PC_REG(15)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Monitor: all expectations queued during the current cycle are compared at the falling edge.
  always @(negedge CLK) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = exp_q.pop_front();
      case (e.sel)
        SEL_RD0:   act = bus.rd[0];
        SEL_RD1:   act = bus.rd[1];
        SEL_RDB0:  act = {31'd0, bus.rd_busy[0]};
        SEL_RDB1:  act = {31'd0, bus.rd_busy[1]};
        SEL_STALL: act = {31'd0, bus.stall};
        SEL_CNT:   act = {27'd0, bus.busy_cnt};
        default:   act = bus.stall_cycles;
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
      end else begin
        $display("check %s: 0x%08h ok", e.name, act);
      end
    end
  end

  task automatic expect_v(input int sel, input logic [31:0] val, input string name);
    exp_t e;
    e.sel  = sel;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.ra          = '0;
    bus.rd_en       = '0;
    bus.we          = 1'b0;
    bus.wa          = '0;
    bus.wd          = '0;
    bus.issue_valid = 1'b0;
    bus.issue_we    = 1'b0;
    bus.issue_wa    = '0;
    bus.issue_long  = 1'b0;
    bus.kill        = 1'b0;
    bus.kill_wa     = '0;
  endtask

  task automatic issue_long_op(input logic [3:0] dst);
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_we    = 1'b1;
    bus.issue_wa    = dst;
    bus.issue_long  = 1'b1;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
    idle();
    bus.we = 1'b1;
    bus.wa = a;
    bus.wd = d;
  endtask

  initial begin
    RESET = 1'b1;
    bus.pc_plus8 = 32'h108;
    idle();
    step();
    step();
    RESET = 1'b0;

    // Reset state and PC alias
    bus.ra[0] = 4'd3;
    bus.ra[1] = 4'd15;
    expect_v(SEL_RD0, 32'h0, "rst_rd0");
    expect_v(SEL_RD1, 32'h108, "rst_pc_rd1");
    expect_v(SEL_RDB0, 32'h0, "rst_rdb0");
    expect_v(SEL_RDB1, 32'h0, "rst_rdb1");
    expect_v(SEL_CNT, 32'h0, "rst_cnt");
    expect_v(SEL_STALL, 32'h0, "rst_stall");
    expect_v(SEL_SCY, 32'h0, "rst_scy");
    step();

    // Load-use: long op to r4, dependent waits three cycles, then issues on bypassed data
    issue_long_op(4'd4);
    expect_v(SEL_STALL, 32'h0, "lu_issue_stall");
    step();
    for (int c = 0; c < 3; c++) begin
      idle();
      bus.issue_valid = 1'b1;
      bus.rd_en       = 2'b01;
      bus.ra[0]       = 4'd4;
      expect_v(SEL_RDB0, 32'h1, "lu_rdb0");
      expect_v(SEL_STALL, 32'h1, "lu_stall");
      expect_v(SEL_CNT, 32'h1, "lu_cnt");
      step();
    end
    bus.we = 1'b1;
    bus.wa = 4'd4;
    bus.wd = 32'hDEAD;
    expect_v(SEL_RD0, 32'hDEAD, "lu_bypass_rd0");
    expect_v(SEL_RDB0, 32'h0, "lu_bypass_rdb0");
    expect_v(SEL_STALL, 32'h0, "lu_wb_stall");
    expect_v(SEL_SCY, 32'd3, "lu_scy");
    step();
    idle();
    bus.ra[0] = 4'd4;
    expect_v(SEL_RD0, 32'hDEAD, "lu_stored_rd0");
    expect_v(SEL_CNT, 32'h0, "lu_cnt_clear");
    step();

    // WAW hazard on r5
    issue_long_op(4'd5);
    step();
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_we    = 1'b1;
    bus.issue_wa    = 4'd5;
    expect_v(SEL_STALL, 32'h1, "waw_stall");
    step();
    bus.issue_long = 1'b1;
    bus.we = 1'b1;
    bus.wa = 4'd5;
    bus.wd = 32'h55;
    expect_v(SEL_STALL, 32'h0, "waw_wb_stall");
    step();
    idle();
    bus.ra[0] = 4'd5;
    expect_v(SEL_CNT, 32'h1, "waw_cnt");
    expect_v(SEL_RDB0, 32'h1, "waw_still_busy");
    expect_v(SEL_RD0, 32'h55, "waw_rd0");
    expect_v(SEL_SCY, 32'd4, "waw_scy");
    step();
    write_reg(4'd5, 32'h56);
    step();

    // Kill
    write_reg(4'd7, 32'h77);
    step();
    issue_long_op(4'd7);
    step();
    idle();
    expect_v(SEL_CNT, 32'h1, "kill_cnt_before");
    bus.kill    = 1'b1;
    bus.kill_wa = 4'd7;
    step();
    idle();
    bus.ra[0] = 4'd7;
    expect_v(SEL_CNT, 32'h0, "kill_cnt_after");
    expect_v(SEL_RD0, 32'h77, "kill_rd0");
    expect_v(SEL_RDB0, 32'h0, "kill_rdb0");
    step();
    issue_long_op(4'd7);
    bus.kill    = 1'b1;
    bus.kill_wa = 4'd7;
    step();
    idle();
    bus.ra[0] = 4'd7;
    expect_v(SEL_CNT, 32'h1, "killset_cnt");
    expect_v(SEL_RDB0, 32'h1, "killset_rdb0");
    bus.kill    = 1'b1;
    bus.kill_wa = 4'd7;
    step();

    // Unused read port and PC-register writes
    issue_long_op(4'd6);
    step();
    idle();
    bus.issue_valid = 1'b1;
    bus.rd_en       = 2'b01;
    bus.ra[0]       = 4'd3;
    bus.ra[1]       = 4'd6;
    expect_v(SEL_RDB1, 32'h1, "unused_rdb1");
    expect_v(SEL_STALL, 32'h0, "unused_stall");
    step();
    write_reg(4'd15, 32'hBAD);
    bus.kill    = 1'b1;
    bus.kill_wa = 4'd6;
    bus.ra[1]   = 4'd15;
    expect_v(SEL_RD1, 32'h108, "pcw_bypass_rd1");
    step();
    issue_long_op(4'd15);
    bus.pc_plus8 = 32'h200;
    bus.ra[0]    = 4'd15;
    expect_v(SEL_RD0, 32'h200, "pc_rd0");
    expect_v(SEL_RDB0, 32'h0, "pc_rdb0");
    step();
    idle();
    expect_v(SEL_CNT, 32'h0, "pc_never_busy");
    step();

    // Reset in the middle of a stall
    write_reg(4'd2, 32'h22);
    step();
    issue_long_op(4'd2);
    step();
    issue_long_op(4'd9);
    step();
    idle();
    bus.issue_valid = 1'b1;
    bus.rd_en       = 2'b01;
    bus.ra[0]       = 4'd2;
    expect_v(SEL_STALL, 32'h1, "mid_stall");
    expect_v(SEL_CNT, 32'h2, "mid_cnt");
    expect_v(SEL_RD0, 32'h22, "mid_rd0");
    step();
    RESET   = 1'b1;
    bus.we  = 1'b1;
    bus.wa  = 4'd3;
    bus.wd  = 32'h99;
    step();
    RESET  = 1'b0;
    bus.we = 1'b0;
    bus.ra[1] = 4'd3;
    expect_v(SEL_CNT, 32'h0, "postrst_cnt");
    expect_v(SEL_STALL, 32'h0, "postrst_stall");
    expect_v(SEL_SCY, 32'h0, "postrst_scy");
    expect_v(SEL_RD0, 32'h0, "postrst_rd0");
    expect_v(SEL_RD1, 32'h0, "postrst_rd1");
    step();

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge CLK);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file for the decode stage with a per-register busy scoreboard, same-cycle write-through bypass and an issue-stall generator. It replaces the fixed two-port, 16-entry file and lets decode hold instructions whose sources or destination are still awaiting a long-latency result, such as a load. It sits between the decoder/control unit, which supply read addresses and issue information, and writeback, which supplies the write port.

## Interface
- BITS, 32, data width
- NREGS, 16, architectural register count; power of two, at least 4; AW = $clog2(NREGS)
- NRD, 2, number of read ports, 1..4
- PC_REG, NREGS-1, index whose reads return pc_plus8

- CLK  in  1  clock
- RESET  in  1  reset; one clock; reset is synchronous and active-high
- ra  in  NRD×AW  read addresses
- rd_en  in  NRD  read port used by the instruction in decode
- rd  out  NRD×BITS  read data
- rd_busy  out  NRD  source register pending
- pc_plus8  in  BITS  value returned for PC_REG reads
- we  in  1  writeback enable
- wa  in  AW  writeback address
- wd  in  BITS  writeback data
- issue_valid  in  1  decode holds a valid instruction
- issue_we  in  1  instruction writes a register
- issue_wa  in  AW  its destination
- issue_long  in  1  destination result is long-latency and must be marked busy
- kill  in  1  cancel one pending long op
- kill_wa  in  AW  destination of the cancelled op
- stall  out  1  decode must hold
- busy_cnt  out  AW+1  number of busy registers
- stall_cycles  out  32  saturating count of stalled cycles

## Operation
- **Storage:** NREGS×BITS array plus an NREGS-bit busy vector.
- **Reads, combinational per port i:**
  - ra[i]==PC_REG: rd = pc_plus8 and rd_busy = 0.
  - Otherwise, if we && wa==ra[i]: rd = wd (bypass) and rd_busy = 0.
  - Otherwise: rd = array[ra[i]] and rd_busy = busy[ra[i]].
- **Write:** on a CLK edge with we && wa!=PC_REG, array[wa] <= wd. Writes to PC_REG are dropped.
- **stall** = issue_valid && ( |(rd_en & rd_busy) || (issue_we && issue_wa!=PC_REG && busy[issue_wa] && !(we && wa==issue_wa)) ).
- **Busy update per edge, evaluated in this order (later wins):**
  - clear busy[wa] when we;
  - clear busy[kill_wa] when kill;
  - set busy[issue_wa] when issue_valid && issue_we && issue_long && !stall && issue_wa!=PC_REG.
- **Simultaneous clear and set of the same register:** set wins, because it belongs to the newer op.
- busy_cnt = popcount(busy) on registered state.
- **stall_cycles:** increments when stall is high; holds at 0xFFFF_FFFF.

## Timing
- Read-to-data latency is 0 cycles (combinational). Writes and busy changes are visible the cycle after the edge.
- **A long op issued in cycle t:**
  - a dependent instruction in t+1 sees rd_busy=1 and stall=1;
  - if writeback occurs in cycle w, the dependent instruction issues in w, using bypassed data, with no extra bubble.
- **RESET high at an edge:**
  - every array entry becomes 0, busy becomes 0 and stall_cycles becomes 0;
  - we, issue and kill in that cycle are ignored;
  - after reset, rd = 0 (or pc_plus8 for PC_REG), rd_busy = 0, stall = 0 and busy_cnt = 0.
- Reset mid-stall drops all pending state; stall deasserts the cycle after reset.
- All busy registers set gives busy_cnt = NREGS-1 maximum, since PC_REG is never busy. There is no overflow path.

## Structure
- **Package rf_pkg:**
  - localparam helpers for AW;
  - typedef reg_addr_t (logic [AW-1:0]) for the default configuration;
  - constant PC_REG_DEFAULT.
- **Sub-module busy_table:** owns the busy vector, the set/clear priority, busy_cnt and the busy lookup per read port.
- **Top level:** owns the data array, the bypass muxes, PC substitution, stall and stall_cycles.

## Test plan
- **Reset and PC read:** reset, then read ra={3,15} with pc_plus8=0x108 -> rd={0,0x108}, rd_busy=0, busy_cnt=0.
- **Load-use:**
  - issue_wa=4, issue_long=1 at t;
  - at t+1, ra[0]=4 with rd_en=1 -> stall=1 for 3 cycles;
  - at t+4, we=1, wa=4, wd=0xDEAD -> same-cycle rd[0]=0xDEAD and stall=0; stall_cycles=3.
- **WAW hazard:** busy[5]=1, then issue_we=1, issue_wa=5 with no sources -> stall=1. With we, wa=5 in the same cycle -> stall=0 and busy[5] stays 1, because the new op is long.
- **Kill:**
  - busy[7]=1; kill=1, kill_wa=7 -> next cycle busy_cnt drops by 1 and a read of r7 returns the old array value with rd_busy=0;
  - kill and set on r7 in the same cycle -> busy[7]=1.
- **Unused port and PC writes:** rd_en[1]=0 with ra[1] busy -> stall=0. Writing wa=15 -> array unchanged and reads still return pc_plus8.
- **Reset mid-operation:** busy={2,9} with stall active, RESET for one cycle -> busy_cnt=0, stall=0, stall_cycles=0 and r2 reads 0.
